// File: rtl/fpu_sp_add_issue.sv
// fpu_sp_add_issue: operand FIFO plus a one-op-in-flight issue FSM in front of
// the single-precision adder. The adder only holds Out for one cycle, so the
// result is captured here and returned with its tag on a valid/ready port.
// Optional feature macro: FPU_ADD_ZERO_BYPASS_EN (zero-operand pairs resolved
// at the pop, never sent to the adder).
module fpu_sp_add_issue #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_dval,
    input  logic [31:0]      add_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int LW   = (LAT > 1) ? $clog2(LAT) : 1;

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RET} state_t;

    op_t              mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    state_t           state_q, state_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic [31:0]      a_q, a_d, b_q, b_d, res_q, res_d;
    logic [TAG_W-1:0] optag_q, optag_d, rtag_q, rtag_d;
    logic             push, pop, empty, full;
    op_t              head;
    logic             byp;
    logic [31:0]      byp_res;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNTW'(DEPTH));
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rptr_q];

`ifdef FPU_ADD_ZERO_BYPASS_EN
    // Zero-operand pairs resolve to the other operand (or a signed zero)
    always_comb begin
        byp = (head.a[30:0] == '0) || (head.b[30:0] == '0);
        if ((head.a[30:0] == '0) && (head.b[30:0] == '0))
            byp_res = {head.a[31] & head.b[31], 31'b0};
        else if (head.a[30:0] == '0)
            byp_res = head.b;
        else
            byp_res = head.a;
    end
`else
    assign byp     = 1'b0;
    assign byp_res = '0;
`endif

    // Next-state: FSM, op registers, result capture and pop decision
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        a_d     = a_q;
        b_d     = b_q;
        optag_d = optag_q;
        res_d   = res_q;
        rtag_d  = rtag_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:  pop = !empty;
            ISSUE: begin
                state_d = WAIT;
                lat_d   = LW'(LAT - 1);
            end
            WAIT: begin
                // Adder zeroes Out on this same edge, so this is the only sample
                if (lat_q == '0) begin
                    res_d   = add_out;
                    rtag_d  = optag_q;
                    state_d = RET;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RET: begin
                if (out_ready) begin
                    pop = !empty;
                    if (empty) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            if (byp) begin
                res_d   = byp_res;
                rtag_d  = head.tag;
                state_d = RET;
            end else begin
                a_d     = head.a;
                b_d     = head.b;
                optag_d = head.tag;
                state_d = ISSUE;
            end
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n)
    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CNTW'(push) - CNTW'(pop);
    end

    // FIFO storage, no reset needed: entries are only read when counted valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {in_a, in_b, in_tag};
    end

    // State registers, asynchronous reset drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            lat_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            optag_q <= '0;
            res_q   <= '0;
            rtag_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            lat_q   <= lat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            optag_q <= optag_d;
            res_q   <= res_d;
            rtag_q  <= rtag_d;
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_dval  = (state_q == ISSUE);
    assign out_valid = (state_q == RET);
    assign out_res   = res_q;
    assign out_tag   = rtag_q;
    assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_fpu_sp_add_issue.sv
// Scoreboard bench for fpu_sp_add_issue: a behavioural adder (real arithmetic,
// LAT-cycle output, cleared when dval=0) feeds the DUT; expectations are queued
// at acceptance and checked by a negedge monitor.
module tb_fpu_sp_add_issue;
    localparam int DEPTH = 2;
    localparam int TAG_W = 4;
    localparam int LAT   = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0, in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      add_a, add_b, add_out;
    logic             add_dval;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_res;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    fpu_sp_add_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .add_a(add_a), .add_b(add_b), .add_dval(add_dval), .add_out(add_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---- reference arithmetic (single <-> double through real) ----
    function automatic real s2r(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:23] == 8'd0) d = {s[31], 63'b0};
        else d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'b0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2s(s2r(a) + s2r(b));
    endfunction

    function automatic logic is_byp(input logic [31:0] a, input logic [31:0] b);
`ifdef FPU_ADD_ZERO_BYPASS_EN
        return (a[30:0] == 31'd0) || (b[30:0] == 31'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b);
        if (is_byp(a, b)) begin
            if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return {a[31] & b[31], 31'b0};
            if (a[30:0] == 31'd0) return b;
            return a;
        end
        return fadd(a, b);
    endfunction

    function automatic logic [31:0] rnd_fp();
        if ($urandom_range(7) == 0) return {1'($urandom_range(1)), 31'b0};
        return {1'($urandom_range(1)), 8'($urandom_range(150, 100)), 23'($urandom)};
    endfunction

    // ---- behavioural adder: Out valid LAT cycles after dval edge, else 0 ----
    logic [31:0] apipe [LAT];
    initial for (int i = 0; i < LAT; i++) apipe[i] = '0;
    always @(posedge clk) begin
        apipe[0] <= add_dval ? fadd(add_a, add_b) : 32'd0;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign add_out = apipe[LAT-1];

    // ---- scoreboard state ----
    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t        expq[$];
    logic [63:0] opq[$];
    longint      cons_cyc[$];
    int          acc = 0, issued = 0;
    longint      cyc = 0;
    logic        prev_dval = 1'b0, prev_hold = 1'b0;
    logic [31:0] prev_res = '0;
    logic [TAG_W-1:0] prev_tag = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: operand issue, FIFO occupancy, result order and hold stability
    always @(negedge clk) begin
        if (!rst) begin
            if (add_dval) begin
                chk("dval_one_cycle", 64'(prev_dval), 64'd0);
                if (opq.size() == 0) chk("dval_unexpected", 64'd1, 64'd0);
                else begin
                    logic [63:0] op;
                    op = opq.pop_front();
                    chk("add_a", 64'(add_a), 64'(op[63:32]));
                    chk("add_b", 64'(add_b), 64'(op[31:0]));
                end
                issued++;
            end
            prev_dval = add_dval;
`ifndef FPU_ADD_ZERO_BYPASS_EN
            chk("in_ready_occ", 64'(in_ready), 64'((acc - issued) < DEPTH));
`endif
            if (in_valid && in_ready) begin
                exp_t e;
                acc++;
                e.res = ref_res(in_a, in_b);
                e.tag = in_tag;
                expq.push_back(e);
                if (!is_byp(in_a, in_b)) opq.push_back({in_a, in_b});
            end
            if (prev_hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_res", 64'(out_res), 64'(prev_res));
                chk("hold_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                cons_cyc.push_back(cyc);
                if (expq.size() == 0) chk("result_unexpected", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("result_res", 64'(out_res), 64'(e.res));
                    chk("result_tag", 64'(out_tag), 64'(e.tag));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_res  = out_res;
            prev_tag  = out_tag;
        end
    end

    // ---- stimulus helpers (called and returning at posedge+1) ----
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("push_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((expq.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n < 500), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_result(output logic [31:0] r, output logic [TAG_W-1:0] t, output longint when);
        int n = 0;
        r = '0; t = '0;
        while (n < 200) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        chk("result_timeout", 64'(n < 200), 64'd1);
        r = out_res; t = out_tag; when = cyc;
    endtask

    logic [31:0]      r;
    logic [TAG_W-1:0] t;
    longint           e0, when;
    int               d0;

    initial begin
        // reset state
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_add_dval", 64'(add_dval), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_res", 64'(out_res), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_add_a", 64'({add_a, add_b}), 64'd0);
        #21 rst = 1'b0;
        @(posedge clk); #1;

        // 1: 1.0 + 2.0, latency and single dval pulse
        d0 = issued;
        push(32'h3F800000, 32'h40000000, 4'd3);
        e0 = cyc;
        wait_result(r, t, when);
        chk("t1_res", 64'(r), 64'h40400000);
        chk("t1_tag", 64'(t), 64'd3);
        chk("t1_latency", 64'(when - e0), 64'd3);
        wait_idle();
        chk("t1_dvals", 64'(issued - d0), 64'd1);

        // 2: 3.0 + -1.0
        push(32'h40400000, 32'hBF800000, 4'd5);
        wait_result(r, t, when);
        chk("t2_res", 64'(r), 64'h40000000);
        wait_idle();

        // 3: back-pressure, full FIFO, in-order release without bubbles
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h3F800000 + 32'(i << 20), 32'h40000000, 4'(i));
        wait_result(r, t, when);
        chk("t3_first_tag", 64'(t), 64'd0);
        chk("t3_full_in_ready", 64'(in_ready), 64'd0);
        cons_cyc.delete();
        fork
            push(32'h40800000, 32'h3F000000, 4'd3);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_idle();
        chk("t3_count", 64'(cons_cyc.size()), 64'd4);
        for (int i = 1; i < cons_cyc.size(); i++)
            chk("t3_no_bubble", 64'(cons_cyc[i] - cons_cyc[i-1]), 64'(LAT + 2));

        // 4: random stream, in_valid mostly held, data changes every cycle
        for (int c = 0; c < 400; c++) begin
            in_valid  = (c < 60) ? 1'b1 : ($urandom_range(3) != 0);
            out_ready = (c < 60) ? 1'b1 : ($urandom_range(3) != 0);
            in_a = rnd_fp(); in_b = rnd_fp(); in_tag = 4'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_idle();

        // 5: async reset mid-WAIT with 2 queued
        for (int i = 0; i < 3; i++) push(32'h41000000, 32'h3F800000 + 32'(i), 4'(8 + i));
        #2 rst = 1'b1;
        #1;
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_add_dval", 64'(add_dval), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        chk("t5_add_ab", 64'({add_a, add_b}), 64'd0);
        chk("t5_out_res", 64'({out_res, 28'd0, out_tag}), 64'd0);
        expq.delete(); opq.delete();
        acc = 0; issued = 0; prev_dval = 1'b0; prev_hold = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_no_stale", 64'({out_valid, busy}), 64'd0);
        end
        @(posedge clk); #1;
        push(32'h40000000, 32'h40000000, 4'd12);
        wait_result(r, t, when);
        chk("t5_new_res", 64'(r), 64'h40800000);
        wait_idle();

        // 6: zero operand
        d0 = issued;
        push(32'h00000000, 32'h40A00000, 4'd6);
        e0 = cyc;
        wait_result(r, t, when);
        chk("t6_res", 64'(r), 64'h40A00000);
        chk("t6_tag", 64'(t), 64'd6);
        wait_idle();
`ifdef FPU_ADD_ZERO_BYPASS_EN
        chk("t6_latency", 64'(when - e0), 64'd1);
        chk("t6_dvals", 64'(issued - d0), 64'd0);
`else
        chk("t6_latency", 64'(when - e0), 64'd3);
        chk("t6_dvals", 64'(issued - d0), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
